multi_voice_chorus: RTL and testbench
=====================================

# multi_voice_chorus

Parametrised chorus engine that generalises the two-voice chorus to 1–4 modulated voices on one shared delay line. Each voice has its own LFSR delay modulation and glides smoothly toward each new delay target. The block adds wet/dry gain, saturation and optional stereo spread. It sits between the audio codec receive path and the output mixer, and drives a single external synchronous RAM holding the delay line.

## Interface
Parameters:
- WIDTH, 16: sample width, signed two's complement
- VOICES, 2: number of chorus voices, legal 1..4
- DEPTH_LOG2, 11: delay-line depth is 2^DEPTH_LOG2 words
- BASE_DELAY, 480: minimum delay in samples
- MOD_RANGE, 720: modulation span in samples; BASE_DELAY+MOD_RANGE < 2^DEPTH_LOG2 is required
- SWEEP_LEN, 480: samples between LFSR steps per voice
- SEED, 123: LFSR seed base; voice v seed = (SEED + 97*v) mod 512, and 1 is used if that result is 0

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle strobe, new stereo sample present
- leftSampleIn  in  WIDTH  left input, signed
- rightSampleIn  in  WIDTH  right input, signed
- wet_gain  in  8  unsigned wet gain; out_wet = sum*wet_gain/256
- spread  in  1  0 = all voices to both channels; 1 = even voices left, odd voices right
- leftSampleOut  out  WIDTH  left output, signed, registered
- rightSampleOut  out  WIDTH  right output, signed, registered
- out_valid  out  1  one-cycle pulse, outputs updated
- overrun  out  1  one-cycle pulse, strobe dropped while busy
- mem_addr  out  DEPTH_LOG2  delay-line address
- mem_wdata  out  WIDTH  write data
- mem_we  out  1  write enable
- mem_rdata  in  WIDTH  read data, valid one cycle after mem_addr is presented

## Operation
- Reset values: all outputs 0, wr_ptr=0, cur_d[v]=tgt_d[v]=BASE_DELAY, lfsr[v]=seed_v, sweep_cnt[v]=0, prime_cnt=0, state IDLE. RAM contents are not cleared.
- FSM states: IDLE → RD_ADDR(v) → RD_DATA(v), repeated for v=0..VOICES-1 → WRITE → DONE → IDLE.
- IDLE:
  - On sample_valid, latch both inputs.
  - mono = (L+R)>>>1, computed at WIDTH+1 bits and then truncated to WIDTH.
  - Clear the accumulators.
- RD_ADDR(v): mem_addr = (wr_ptr − cur_d[v]) mod 2^DEPTH_LOG2, mem_we=0.
- RD_DATA(v): capture mem_rdata. Add it to accL and/or accR according to `spread`.
  - With VOICES=1 and spread=1, voice 0 feeds both channels.
- WRITE: mem_addr=wr_ptr, mem_wdata=mono, mem_we=1. wr_ptr increments and wraps at 2^DEPTH_LOG2.
- DONE:
  - Channel out = sat_WIDTH(dry + ((acc*wet_gain)>>>8)).
  - Accumulators are WIDTH+2 bits; the product is WIDTH+10 bits.
  - Assert out_valid.
  - Update modulation state for every voice as below.
- Modulation per voice, evaluated in DONE:
  - Glide: if cur_d<tgt_d then cur_d+1; if cur_d>tgt_d then cur_d−1; otherwise hold.
  - Sweep: sweep_cnt increments. At SWEEP_LEN−1 it wraps to 0 and steps the LFSR.
  - LFSR: 9-bit, feedback = b8^b6^b4, shifted in at b0.
  - New target: tgt_d = BASE_DELAY + ((MOD_RANGE*lfsr_new)>>9).
- Priming: while prime_cnt < BASE_DELAY+MOD_RANGE, wet contribution is forced to 0. prime_cnt increments once per written sample and saturates.
- Boundaries:
  - sample_valid outside IDLE: the strobe is ignored and overrun pulses in the same cycle. The in-progress frame is unaffected.
  - Read and write in the same frame never collide, because cur_d ≥ BASE_DELAY > 0.
  - Read-address wrap uses modular subtraction.
  - wet_gain=0 gives pure dry output, bit-exact.
  - reset mid-frame: the FSM returns to IDLE on the next edge, and mem_we is 0 in that cycle.

## Timing
- Frame length is 2*VOICES+3 cycles, counted from the strobe cycle (IDLE) through DONE.
- out_valid pulses 2*VOICES+2 cycles after the cycle in which sample_valid is sampled high.
- Minimum strobe spacing is 2*VOICES+3 cycles.
- mem_we is high exactly one cycle per frame.
- Outputs hold their values between out_valid pulses.

## Structure
- Package chorus_pkg holds:
  - state enum
  - LFSR tap constant
  - sat() function (clamp to WIDTH)
  - seed function
- Sub-module chorus_lfsr9: 9-bit LFSR with step enable and seed parameter. One instance per voice via generate.

## Test plan
- Reset, then 1 strobe with L=R=1000 and wet_gain=0 → out_valid at cycle 6 (VOICES=2); outputs both 1000; mem_we=1 once, at wr addr 0 with wdata 1000.
- Impulse L=R=8000 then zeros, wet_gain=128, spread=0, VOICES=1, after priming → right output shows 4000 exactly BASE_DELAY frames after the impulse, since the voice-0 target stays 480 until the first sweep.
- L=R=30000, wet_gain=255, after priming → outputs saturate at 32767, with no wrap to negative.
- Strobe held for 2 consecutive cycles → overrun pulse on the second cycle; exactly one out_valid.
- Run 3*SWEEP_LEN frames → cur_d changes by at most 1 per frame. tgt_d after the first step equals 480+((720*lfsr1)>>9), with lfsr1=246 for seed 123.
- spread=1, VOICES=2, impulse → voice-0 echo on left only, voice-1 echo on right only.

Source files
------------

// File: rtl/chorus_pkg.sv
// chorus_pkg: shared types and helpers for the multi-voice chorus.
// Holds the FSM state enum, LFSR taps, saturation and per-voice seed.
package chorus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  // Feedback taps b8, b6, b4
  localparam logic [8:0] LFSR_TAPS = 9'h150;

  // Clamp a 32-bit signed value into a w-bit signed range
  function automatic logic signed [31:0] sat(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Spread the voice seeds apart; an all-zero LFSR would lock up
  function automatic logic [8:0] voice_seed(
    input int seed,
    input int v
  );
    int s;
    s = (seed + 97 * v) % 512;
    if (s == 0) s = 1;
    return s[8:0];
  endfunction

endpackage

// File: rtl/chorus_lfsr9.sv
// chorus_lfsr9: 9-bit Fibonacci LFSR with step enable.
// Ports: clk, reset (sync, high), step; nxt = value after the next step.
module chorus_lfsr9
  import chorus_pkg::*;
#(
  parameter logic [8:0] SEED = 9'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [8:0] nxt
);

  logic [8:0] q;
  logic       fb;

  assign fb  = ^(q & LFSR_TAPS);
  assign nxt = {q[7:0], fb};

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (step) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/multi_voice_chorus.sv
// multi_voice_chorus: 1..4 LFSR-modulated voices on one external delay RAM.
// In: CLOCK_50, reset, sample_valid, L/R in, wet_gain, spread, mem_rdata.
// Out: L/R out, out_valid, overrun, mem_addr/mem_wdata/mem_we.
module multi_voice_chorus
  import chorus_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int VOICES     = 2,
  parameter int DEPTH_LOG2 = 11,
  parameter int BASE_DELAY = 480,
  parameter int MOD_RANGE  = 720,
  parameter int SWEEP_LEN  = 480,
  parameter int SEED       = 123
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [WIDTH-1:0]      leftSampleIn,
  input  logic [WIDTH-1:0]      rightSampleIn,
  input  logic [7:0]            wet_gain,
  input  logic                  spread,
  output logic [WIDTH-1:0]      leftSampleOut,
  output logic [WIDTH-1:0]      rightSampleOut,
  output logic                  out_valid,
  output logic                  overrun,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int VIW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int PW  = WIDTH + 10;
  localparam int DW  = DEPTH_LOG2;

  localparam logic [DW-1:0]  PRIME_MAX  = DW'(BASE_DELAY + MOD_RANGE);
  localparam logic [DW-1:0]  BASE_D     = DW'(BASE_DELAY);
  localparam logic [15:0]    SWEEP_LAST = 16'(SWEEP_LEN - 1);
  localparam logic [VIW-1:0] LAST_V     = VIW'(VOICES - 1);

  state_t state;
  state_t state_n;

  logic [VIW-1:0] voice;
  logic [VIW-1:0] voice_n;

  logic signed [WIDTH-1:0] l_in;
  logic signed [WIDTH-1:0] r_in;
  logic signed [WIDTH-1:0] mono;
  logic signed [WIDTH+1:0] acc_l;
  logic signed [WIDTH+1:0] acc_r;
  logic [DW-1:0]           wr_ptr;
  logic [DW-1:0]           prime_cnt;

  logic [DW-1:0] cur_d     [VOICES];
  logic [DW-1:0] tgt_d     [VOICES];
  logic [15:0]   sweep_cnt [VOICES];
  logic [8:0]    lfsr_nx   [VOICES];
  logic [VOICES-1:0] step;

  logic signed [WIDTH:0]   sum_lr;
  logic signed [WIDTH-1:0] mono_n;
  logic signed [WIDTH+1:0] rd_x;
  logic signed [PW-1:0]    prod_l;
  logic signed [PW-1:0]    prod_r;
  logic signed [31:0]      mix_l;
  logic signed [31:0]      mix_r;
  logic [WIDTH-1:0]        out_l;
  logic [WIDTH-1:0]        out_r;
  logic                    to_l;
  logic                    to_r;
  logic                    primed;

  // New glide target from the freshly stepped LFSR value
  function automatic logic [DW-1:0] target(
    input logic [8:0] s
  );
    logic [31:0] p;
    p = 32'(MOD_RANGE) * {23'd0, s};
    return DW'(32'(BASE_DELAY) + (p >> 9));
  endfunction

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    chorus_lfsr9 #(
      .SEED (voice_seed(SEED, v))
    ) u_lfsr (
      .clk   (CLOCK_50),
      .reset (reset),
      .step  (step[v]),
      .nxt   (lfsr_nx[v])
    );
  end

  always_comb begin
    step = '0;
    for (int v = 0; v < VOICES; v++) begin
      step[v] = (state == S_DONE) &&
                (sweep_cnt[v] == SWEEP_LAST);
    end
  end

  // Datapath: mono mix, read routing, wet scaling
  always_comb begin
    sum_lr = (WIDTH+1)'($signed(leftSampleIn)) +
             (WIDTH+1)'($signed(rightSampleIn));
    mono_n = WIDTH'(sum_lr >>> 1);
    rd_x   = (WIDTH+2)'($signed(mem_rdata));
    // A lone voice feeds both sides even in spread mode
    to_l   = !spread || (VOICES == 1) || !voice[0];
    to_r   = !spread || (VOICES == 1) || voice[0];
    primed = (prime_cnt == PRIME_MAX);
    prod_l = PW'(acc_l) * PW'($signed({1'b0, wet_gain}));
    prod_r = PW'(acc_r) * PW'($signed({1'b0, wet_gain}));
    mix_l  = 32'(l_in) +
             (primed ? 32'(prod_l >>> 8) : 32'sd0);
    mix_r  = 32'(r_in) +
             (primed ? 32'(prod_r >>> 8) : 32'sd0);
    out_l  = WIDTH'(sat(mix_l, WIDTH));
    out_r  = WIDTH'(sat(mix_r, WIDTH));
  end

  always_comb begin
    state_n = state;
    voice_n = voice;
    unique case (state)
      S_IDLE: begin
        voice_n = '0;
        if (sample_valid) state_n = S_RD_ADDR;
      end
      S_RD_ADDR: state_n = S_RD_DATA;
      S_RD_DATA: begin
        if (voice == LAST_V) begin
          state_n = S_WRITE;
        end else begin
          voice_n = voice + VIW'(1);
          state_n = S_RD_ADDR;
        end
      end
      S_WRITE: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Memory port; reset forces a quiet bus in the same cycle
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (!reset) begin
      unique case (state)
        S_RD_ADDR: mem_addr = wr_ptr - cur_d[voice];
        S_WRITE: begin
          mem_addr  = wr_ptr;
          mem_wdata = mono;
          mem_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign overrun = sample_valid && !reset &&
                   (state != S_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state          <= S_IDLE;
      voice          <= '0;
      l_in           <= '0;
      r_in           <= '0;
      mono           <= '0;
      acc_l          <= '0;
      acc_r          <= '0;
      wr_ptr         <= '0;
      prime_cnt      <= '0;
      leftSampleOut  <= '0;
      rightSampleOut <= '0;
      out_valid      <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        cur_d[v]     <= BASE_D;
        tgt_d[v]     <= BASE_D;
        sweep_cnt[v] <= '0;
      end
    end else begin
      state     <= state_n;
      voice     <= voice_n;
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          acc_l <= '0;
          acc_r <= '0;
          if (sample_valid) begin
            l_in <= $signed(leftSampleIn);
            r_in <= $signed(rightSampleIn);
            mono <= mono_n;
          end
        end
        S_RD_DATA: begin
          if (to_l) acc_l <= acc_l + rd_x;
          if (to_r) acc_r <= acc_r + rd_x;
        end
        S_WRITE: begin
          wr_ptr <= wr_ptr + DW'(1);
          if (!primed) prime_cnt <= prime_cnt + DW'(1);
          leftSampleOut  <= out_l;
          rightSampleOut <= out_r;
          out_valid      <= 1'b1;
        end
        S_DONE: begin
          for (int v = 0; v < VOICES; v++) begin
            if (cur_d[v] < tgt_d[v]) begin
              cur_d[v] <= cur_d[v] + DW'(1);
            end else if (cur_d[v] > tgt_d[v]) begin
              cur_d[v] <= cur_d[v] - DW'(1);
            end
            if (step[v]) begin
              sweep_cnt[v] <= '0;
              tgt_d[v]     <= target(lfsr_nx[v]);
            end else begin
              sweep_cnt[v] <= sweep_cnt[v] + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_voice_chorus.sv
// tb_multi_voice_chorus: directed + random frames vs a frame-level model.
// Models the delay RAM and the chorus behaviour per sample frame.
module tb_multi_voice_chorus;

  localparam int W  = 16;
  localparam int V  = 2;
  localparam int DL = 11;
  localparam int BD = 480;
  localparam int MR = 720;
  localparam int SL = 480;
  localparam int SD = 123;
  localparam int PM = BD + MR;
  localparam int NW = 1 << DL;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [W-1:0]  leftSampleIn;
  logic [W-1:0]  rightSampleIn;
  logic [7:0]    wet_gain;
  logic          spread;
  logic [W-1:0]  leftSampleOut;
  logic [W-1:0]  rightSampleOut;
  logic          out_valid;
  logic          overrun;
  logic [DL-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_we;
  logic [W-1:0]  mem_rdata;

  multi_voice_chorus #(
    .WIDTH(W), .VOICES(V), .DEPTH_LOG2(DL),
    .BASE_DELAY(BD), .MOD_RANGE(MR),
    .SWEEP_LEN(SL), .SEED(SD)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .leftSampleIn   (leftSampleIn),
    .rightSampleIn  (rightSampleIn),
    .wet_gain       (wet_gain),
    .spread         (spread),
    .leftSampleOut  (leftSampleOut),
    .rightSampleOut (rightSampleOut),
    .out_valid      (out_valid),
    .overrun        (overrun),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [W-1:0] ram [NW];

  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int vectors    = 0;
  int miscompares = 0;

  int hist [NW];
  int m_wp;
  int m_prime;
  int m_cur  [V];
  int m_tgt  [V];
  int m_lfsr [V];
  int m_sw   [V];

  task automatic check(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    m_wp    = 0;
    m_prime = 0;
    for (int v = 0; v < V; v++) begin
      int s;
      s = (SD + 97 * v) % 512;
      if (s == 0) s = 1;
      m_cur[v]  = BD;
      m_tgt[v]  = BD;
      m_lfsr[v] = s;
      m_sw[v]   = 0;
    end
  endtask

  task automatic model_frame(
    input  int L, input int R, input int g, input bit sp,
    output int eL, output int eR,
    output int emono, output int eaddr
  );
    int mono;
    int aL;
    int aR;
    int s;
    int fb;
    mono = (L + R) >>> 1;
    aL = 0;
    aR = 0;
    for (int v = 0; v < V; v++) begin
      s = hist[(m_wp - m_cur[v]) & (NW - 1)];
      if (!sp || V == 1 || (v % 2) == 0) aL += s;
      if (!sp || V == 1 || (v % 2) == 1) aR += s;
    end
    if (m_prime >= PM) begin
      eL = clamp(L + ((aL * g) >>> 8));
      eR = clamp(R + ((aR * g) >>> 8));
    end else begin
      eL = L;
      eR = R;
    end
    hist[m_wp] = mono;
    emono = mono;
    eaddr = m_wp;
    m_wp = (m_wp + 1) % NW;
    if (m_prime < PM) m_prime++;
    for (int v = 0; v < V; v++) begin
      if (m_cur[v] < m_tgt[v]) m_cur[v]++;
      else if (m_cur[v] > m_tgt[v]) m_cur[v]--;
      m_sw[v]++;
      if (m_sw[v] == SL) begin
        m_sw[v] = 0;
        fb = ((m_lfsr[v] >> 8) ^ (m_lfsr[v] >> 6) ^ (m_lfsr[v] >> 4)) & 1;
        m_lfsr[v] = ((m_lfsr[v] << 1) & 511) | fb;
        m_tgt[v] = BD + ((MR * m_lfsr[v]) / 512);
      end
    end
  endtask

  task automatic run_frame(
    input int L, input int R, input int g,
    input bit sp, input bit hold2
  );
    int eL, eR, em, ea, c, wecnt;
    bit got;
    logic signed [31:0] lat, wa, wd, oL, oR;
    model_frame(L, R, g, sp, eL, eR, em, ea);
    leftSampleIn  = 16'(L);
    rightSampleIn = 16'(R);
    wet_gain      = 8'(g);
    spread        = sp;
    sample_valid  = 1'b1;
    @(posedge CLOCK_50);
    #1;
    if (!hold2) sample_valid = 1'b0;
    c = 0;
    got = 0;
    wecnt = 0;
    lat = -1;
    wa = -1;
    wd = -1;
    oL = 'x;
    oR = 'x;
    while (!got && c < 4 * V + 10) begin
      @(negedge CLOCK_50);
      c++;
      if (mem_we === 1'b1) begin
        wecnt++;
        wa = 32'(mem_addr);
        wd = 32'($signed(mem_wdata));
      end
      if (out_valid === 1'b1) begin
        got = 1;
        lat = c;
        oL = 32'($signed(leftSampleOut));
        oR = 32'($signed(rightSampleOut));
      end
      if (hold2 && c == 1) begin
        check("overrun_pulse", 32'(overrun), 1);
        @(posedge CLOCK_50);
        #1 sample_valid = 1'b0;
      end
    end
    check("done_seen", 32'(got), 1);
    check("latency", lat, 2 * V + 2);
    check("we_count", wecnt, 1);
    check("wr_addr", wa, ea);
    check("wr_data", wd, em);
    check("left", oL, eL);
    check("right", oR, eR);
    @(negedge CLOCK_50);
    check("valid_low", 32'(out_valid), 0);
    check("hold_left", 32'($signed(leftSampleOut)), eL);
    check("hold_right", 32'($signed(rightSampleOut)), eR);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < NW; i++) begin
      ram[i]  = '0;
      hist[i] = 0;
    end
    reset         = 1'b1;
    sample_valid  = 1'b0;
    leftSampleIn  = '0;
    rightSampleIn = '0;
    wet_gain      = '0;
    spread        = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_left", 32'(leftSampleOut), 0);
    check("rst_right", 32'(rightSampleOut), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    reset = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    check("idle_overrun", 32'(overrun), 0);

    run_frame(1000, 1000, 0, 1'b0, 1'b0);

    run_frame(1234, -2000, 200, 1'b0, 1'b1);
    pulses = 0;
    repeat (8) begin
      @(negedge CLOCK_50);
      if (out_valid === 1'b1) pulses++;
    end
    check("no_extra_frame", pulses, 0);

    repeat (1400) begin
      run_frame(int'($urandom_range(65535, 0)) - 32768,
                int'($urandom_range(65535, 0)) - 32768,
                int'($urandom_range(255, 0)),
                1'($urandom_range(1, 0)), 1'b0);
    end

    run_frame(8000, 8000, 128, 1'b1, 1'b0);
    repeat (1250) run_frame(0, 0, 128, 1'b1, 1'b0);

    run_frame(0, 0, 0, 1'b0, 1'b0);
    check("gain0_left", 32'($signed(leftSampleOut)), 0);

    repeat (1300) run_frame(30000, 30000, 255, 1'b0, 1'b0);
    check("sat_left", 32'($signed(leftSampleOut)), 32767);
    check("sat_right", 32'($signed(rightSampleOut)), 32767);

    leftSampleIn  = 16'(500);
    rightSampleIn = 16'(700);
    sample_valid  = 1'b1;
    @(posedge CLOCK_50);
    #1 sample_valid = 1'b0;
    repeat (2 * V + 1) @(negedge CLOCK_50);
    check("we_in_write", 32'(mem_we), 1);
    reset = 1'b1;
    #1;
    check("we_gated", 32'(mem_we), 0);
    @(negedge CLOCK_50);
    check("no_done_after_rst", 32'(out_valid), 0);
    check("we_after_rst", 32'(mem_we), 0);
    reset = 1'b0;
    model_reset();

    repeat (5) begin
      run_frame(int'($urandom_range(65535, 0)) - 32768,
                int'($urandom_range(65535, 0)) - 32768,
                int'($urandom_range(255, 0)),
                1'($urandom_range(1, 0)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
